dmem_arbiter: RTL

- Sequences the 3-stage core's single-port data memory.
- Shares that memory between two requesters:
  - the core load/store path (core_*)
  - an external loader/debug port (ext_*), which preloads and inspects memory in place of backdoor loads
- Round-robin arbitration with a registered memory request and a bus timeout.
- Generates the core pipeline stall while a core access is outstanding.

---
 rtl/dmem_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin arbiter between core load/store path and external loader port
// Registered single-port memory request with bus timeout and core pipeline stall generation.
module dmem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            core_req,
    input  logic            core_we,
    input  logic [AW-1:0]   core_addr,
    input  logic [DW-1:0]   core_wdata,
    input  logic [DW/8-1:0] core_wmask,
    output logic [DW-1:0]   core_rdata,
    output logic            core_done,
    output logic            core_stall,
    input  logic            ext_req,
    input  logic            ext_we,
    input  logic [AW-1:0]   ext_addr,
    input  logic [DW-1:0]   ext_wdata,
    output logic [DW-1:0]   ext_rdata,
    output logic            ext_done,
    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_wmask,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,
    output logic            err,
    output logic            err_sticky
);
    localparam int CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state;
    logic          last_grant;
    logic          win_ext;
    logic [CW-1:0] cnt;
    logic          pick_ext;

    // last_grant = 1 means ext was served last, so a tie goes to the core
    assign pick_ext   = ext_req & (~core_req | ~last_grant);
    assign core_stall = core_req & ~core_done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            win_ext    <= 1'b0;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_wmask  <= '0;
            core_rdata <= '0;
            ext_rdata  <= '0;
            core_done  <= 1'b0;
            ext_done   <= 1'b0;
            err        <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            core_done <= 1'b0;
            ext_done  <= 1'b0;
            err       <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req | ext_req) begin
                        win_ext    <= pick_ext;
                        last_grant <= pick_ext;
                        mem_req    <= 1'b1;
                        cnt        <= '0;
                        state      <= BUSY;
                        if (pick_ext) begin
                            mem_we    <= ext_we;
                            mem_addr  <= ext_addr;
                            mem_wdata <= ext_wdata;
                            mem_wmask <= '1;
                        end else begin
                            mem_we    <= core_we;
                            mem_addr  <= core_addr;
                            mem_wdata <= core_wdata;
                            mem_wmask <= core_wmask;
                        end
                    end
                end
                BUSY: begin
                    // an ack on the final counted cycle takes priority over the abort
                    if (mem_ack) begin
                        mem_req   <= 1'b0;
                        core_done <= ~win_ext;
                        ext_done  <= win_ext;
                        state     <= DONE;
                        if (win_ext) ext_rdata  <= mem_rdata;
                        else         core_rdata <= mem_rdata;
                    end else if (TIMEOUT > 0 && cnt == CW'(TLIM)) begin
                        mem_req    <= 1'b0;
                        core_done  <= ~win_ext;
                        ext_done   <= win_ext;
                        err        <= 1'b1;
                        err_sticky <= 1'b1;
                        state      <= DONE;
                        if (win_ext) ext_rdata  <= '0;
                        else         core_rdata <= '0;
                    end else if (TIMEOUT > 0) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
